// File: rtl/seg_scan_pkg.sv
// rtl/seg_scan_pkg.sv - shared types, constants and digit-field helper for the segment scan controller
package seg_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } scan_state_e;

    localparam int DIGIT_W   = 4;
    localparam int MAX_DIG   = 8;
    localparam int DIG_IDX_W = 3;

    localparam logic [MAX_DIG-1:0] SEL_OFF = '1;

    function automatic logic [DIGIT_W-1:0] digit_field(
        input logic [DIGIT_W*MAX_DIG-1:0] data,
        input logic [DIG_IDX_W-1:0]       idx
    );
        return data[idx*DIGIT_W +: DIGIT_W];
    endfunction

endpackage

// File: rtl/seg_next_digit.sv
// rtl/seg_next_digit.sv - priority finder for the next enabled digit position
module seg_next_digit #(
    parameter int NUM_DIG = 8,
    parameter int IDX_W   = 3
) (
    input  logic [NUM_DIG-1:0] mask,
    input  logic [IDX_W-1:0]   cur,
    input  logic               from_start,
    output logic [IDX_W-1:0]   next_idx,
    output logic               none
);

    // Scan downwards so the lowest qualifying index is the last one written.
    always_comb begin
        next_idx = '0;
        none     = 1'b1;
        for (int i = NUM_DIG - 1; i >= 0; i--) begin
            if (mask[i] && (from_start || (i > int'(cur)))) begin
                next_idx = IDX_W'(i);
                none     = 1'b0;
            end
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed 7-segment scan scheduler; optional digit blink under SEG_SCAN_BLINK_EN
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIG      = 8,
    parameter int DIV          = 12500,
`ifdef SEG_SCAN_BLINK_EN
    parameter int BLINK_FRAMES = 32,
`endif
    parameter int BLANK_CYC    = 16
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [DIGIT_W*NUM_DIG-1:0] FRAME_DATA,
    input  logic [NUM_DIG-1:0]         FRAME_EN,
    input  logic                       FRAME_VALID,
`ifdef SEG_SCAN_BLINK_EN
    input  logic [NUM_DIG-1:0]         BLINK_MASK,
`endif
    output logic                       FRAME_READY,
    output logic [DIGIT_W-1:0]         DIGIT_VAL,
    output logic [NUM_DIG-1:0]         SEG_SEL,
    output logic                       FRAME_START
);

    localparam int IDX_W   = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
    localparam int CNT_MAX = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

    scan_state_e                state, state_n;
    logic [IDX_W-1:0]           cur, cur_n;
    logic [CNT_W-1:0]           cnt, cnt_n;
    logic [DIGIT_W*NUM_DIG-1:0] act_data, pend_data;
    logic [NUM_DIG-1:0]         act_mask, pend_mask;
    logic                       ready_q;
    logic                       commit;
    logic                       frame_start_n;
    logic [NUM_DIG-1:0]         seg_sel_n;
    logic [DIGIT_W-1:0]         digit_val_n;
    logic [DIGIT_W*MAX_DIG-1:0] data_wide;
    logic                       dark;

    logic [NUM_DIG-1:0] start_mask;
    logic [IDX_W-1:0]   start_idx, adv_idx;
    logic               start_none, adv_none;

    // A full pending slot is always what the next commit will install.
    assign start_mask = ready_q ? act_mask : pend_mask;

    seg_next_digit #(.NUM_DIG(NUM_DIG), .IDX_W(IDX_W)) u_start (
        .mask       (start_mask),
        .cur        ('0),
        .from_start (1'b1),
        .next_idx   (start_idx),
        .none       (start_none)
    );

    seg_next_digit #(.NUM_DIG(NUM_DIG), .IDX_W(IDX_W)) u_adv (
        .mask       (act_mask),
        .cur        (cur),
        .from_start (1'b0),
        .next_idx   (adv_idx),
        .none       (adv_none)
    );

    always_comb begin
        state_n       = state;
        cur_n         = cur;
        cnt_n         = cnt + CNT_W'(1);
        commit        = 1'b0;
        frame_start_n = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!ready_q) begin
                    commit = 1'b1;
                    if (!start_none) begin
                        state_n       = SHOW;
                        cur_n         = start_idx;
                        frame_start_n = 1'b1;
                    end
                end
            end
            SHOW: begin
                if (cnt == SHOW_LAST) begin
                    state_n = BLANK;
                    cnt_n   = '0;
                end
            end
            BLANK: begin
                if (cnt == BLANK_LAST) begin
                    cnt_n = '0;
                    if (!adv_none) begin
                        state_n = SHOW;
                        cur_n   = adv_idx;
                    end else begin
                        commit = !ready_q;
                        if (!start_none) begin
                            state_n       = SHOW;
                            cur_n         = start_idx;
                            frame_start_n = 1'b1;
                        end else begin
                            state_n = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Outputs are computed from next-state values so they register alongside the state.
    always_comb begin
        seg_sel_n   = SEL_OFF[NUM_DIG-1:0];
        digit_val_n = '0;
        data_wide   = '0;
        data_wide[DIGIT_W*NUM_DIG-1:0] = commit ? pend_data : act_data;
        if (state_n == SHOW) begin
            digit_val_n = digit_field(data_wide, DIG_IDX_W'(cur_n));
            if (!dark) begin
                seg_sel_n[cur_n] = 1'b0;
            end
        end
    end

`ifdef SEG_SCAN_BLINK_EN
    localparam int FC_W = $clog2(2 * BLINK_FRAMES) + 1;

    logic [FC_W-1:0]    fcnt, fcnt_n;
    logic [NUM_DIG-1:0] blink_act, blink_act_n;
    logic               boundary;

    always_comb begin
        boundary    = (state == BLANK) && (cnt == BLANK_LAST) && adv_none;
        fcnt_n      = fcnt;
        if (boundary) begin
            fcnt_n = (fcnt == FC_W'(2 * BLINK_FRAMES - 1)) ? '0 : fcnt + FC_W'(1);
        end
        blink_act_n = commit ? BLINK_MASK : blink_act;
        dark        = (fcnt_n >= FC_W'(BLINK_FRAMES)) && blink_act_n[cur_n];
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            fcnt      <= '0;
            blink_act <= '0;
        end else begin
            fcnt      <= fcnt_n;
            blink_act <= blink_act_n;
        end
    end
`else
    assign dark = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= IDLE;
            cur         <= '0;
            cnt         <= '0;
            act_data    <= '0;
            act_mask    <= '0;
            pend_data   <= '0;
            pend_mask   <= '0;
            ready_q     <= 1'b1;
            SEG_SEL     <= SEL_OFF[NUM_DIG-1:0];
            DIGIT_VAL   <= '0;
            FRAME_START <= 1'b0;
        end else begin
            state       <= state_n;
            cur         <= cur_n;
            cnt         <= cnt_n;
            SEG_SEL     <= seg_sel_n;
            DIGIT_VAL   <= digit_val_n;
            FRAME_START <= frame_start_n;
            if (commit) begin
                act_data <= pend_data;
                act_mask <= pend_mask;
                ready_q  <= 1'b1;
            end else if (FRAME_VALID && ready_q) begin
                pend_data <= FRAME_DATA;
                pend_mask <= FRAME_EN;
                ready_q   <= 1'b0;
            end
        end
    end

    assign FRAME_READY = ready_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - directed self-checking bench for seg_scan_ctrl (SEG_SCAN_BLINK_EN adds a blink scenario)
module tb_seg_scan_ctrl;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] FRAME_DATA;
    logic [7:0]  FRAME_EN;
    logic        FRAME_VALID;
    logic        FRAME_READY;
    logic [3:0]  DIGIT_VAL;
    logic [7:0]  SEG_SEL;
    logic        FRAME_START;
`ifdef SEG_SCAN_BLINK_EN
    logic [7:0]  BLINK_MASK;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    seg_scan_ctrl #(
        .NUM_DIG      (8),
        .DIV          (4),
`ifdef SEG_SCAN_BLINK_EN
        .BLINK_FRAMES (2),
`endif
        .BLANK_CYC    (2)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .FRAME_DATA  (FRAME_DATA),
        .FRAME_EN    (FRAME_EN),
        .FRAME_VALID (FRAME_VALID),
`ifdef SEG_SCAN_BLINK_EN
        .BLINK_MASK  (BLINK_MASK),
`endif
        .FRAME_READY (FRAME_READY),
        .DIGIT_VAL   (DIGIT_VAL),
        .SEG_SEL     (SEG_SEL),
        .FRAME_START (FRAME_START)
    );

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    // Expected {SEG_SEL, DIGIT_VAL, FRAME_START} at cycle k of a running frame
    // (DIV=4, BLANK_CYC=2): one digit -> period 6, two digits -> period 12.
    function automatic logic [12:0] slot_exp(input int k, input logic [7:0] sa, input logic [3:0] da,
                                             input logic [7:0] sb, input logic [3:0] db, input bit two);
        int p;
        int s;
        p = two ? 12 : 6;
        s = k % p;
        if (s < 4)
            return {sa, da, (s == 0) ? 1'b1 : 1'b0};
        else if (two && s >= 6 && s < 10)
            return {sb, db, 1'b0};
        else
            return {8'hFF, 4'h0, 1'b0};
    endfunction

    task automatic do_reset;
        RESET       = 1'b1;
        FRAME_VALID = 1'b0;
        step();
        step();
        RESET = 1'b0;
    endtask

    // Leaves the bench right after the commit edge, i.e. at cycle 0 of the new frame.
    task automatic load_idle(input logic [31:0] d, input logic [7:0] m);
        FRAME_DATA  = d;
        FRAME_EN    = m;
        FRAME_VALID = 1'b1;
        step();
        FRAME_VALID = 1'b0;
        step();
    endtask

    task automatic test_reset;
        do_reset();
        for (int i = 0; i < 100; i++) begin
            n_checks++;
            if ({SEG_SEL, DIGIT_VAL, FRAME_START, FRAME_READY} !== {8'hFF, 4'h0, 1'b0, 1'b1}) begin
                n_fail++;
                $display("FAIL reset_idle cyc=%0d got %h want %h", i,
                         {SEG_SEL, DIGIT_VAL, FRAME_START, FRAME_READY}, {8'hFF, 4'h0, 1'b0, 1'b1});
            end
            step();
        end
    endtask

    task automatic test_basic;
        logic [12:0] e;
        do_reset();
        FRAME_DATA  = 32'h0000_0021;
        FRAME_EN    = 8'b0000_0011;
        FRAME_VALID = 1'b1;
        step();
        FRAME_VALID = 1'b0;
        n_checks++;
        if ({FRAME_READY, SEG_SEL} !== {1'b0, 8'hFF}) begin
            n_fail++;
            $display("FAIL load_ready got %h want %h", {FRAME_READY, SEG_SEL}, {1'b0, 8'hFF});
        end
        step();
        for (int k = 0; k < 36; k++) begin
            e = slot_exp(k, 8'hFE, 4'd1, 8'hFD, 4'd2, 1'b1);
            n_checks++;
            if ({SEG_SEL, DIGIT_VAL, FRAME_START, FRAME_READY} !== {e, 1'b1}) begin
                n_fail++;
                $display("FAIL basic k=%0d got %h want %h", k,
                         {SEG_SEL, DIGIT_VAL, FRAME_START, FRAME_READY}, {e, 1'b1});
            end
            step();
        end
    endtask

    task automatic test_sparse;
        logic [12:0] e;
        do_reset();
        load_idle(32'h6000_0005, 8'b1000_0001);
        for (int k = 0; k < 36; k++) begin
            e = slot_exp(k, 8'hFE, 4'd5, 8'h7F, 4'd6, 1'b1);
            n_checks++;
            if ({SEG_SEL, DIGIT_VAL, FRAME_START, FRAME_READY} !== {e, 1'b1}) begin
                n_fail++;
                $display("FAIL sparse k=%0d got %h want %h", k,
                         {SEG_SEL, DIGIT_VAL, FRAME_START, FRAME_READY}, {e, 1'b1});
            end
            step();
        end
    endtask

    task automatic test_pending;
        logic [12:0] e;
        logic        r;
        do_reset();
        load_idle(32'h0000_0021, 8'b0000_0011);
        for (int k = 0; k < 30; k++) begin
            if (k < 12) begin
                e = slot_exp(k, 8'hFE, 4'd1, 8'hFD, 4'd2, 1'b1);
                r = (k >= 3) ? 1'b0 : 1'b1;
            end else begin
                e = slot_exp(k - 12, 8'hFB, 4'd7, 8'hFF, 4'd0, 1'b0);
                r = 1'b1;
            end
            n_checks++;
            if ({SEG_SEL, DIGIT_VAL, FRAME_START, FRAME_READY} !== {e, r}) begin
                n_fail++;
                $display("FAIL pending k=%0d got %h want %h", k,
                         {SEG_SEL, DIGIT_VAL, FRAME_START, FRAME_READY}, {e, r});
            end
            if (k == 2) begin
                FRAME_DATA  = 32'h0000_0700;
                FRAME_EN    = 8'b0000_0100;
                FRAME_VALID = 1'b1;
            end else if (k == 3) begin
                FRAME_DATA  = 32'h0000_9000;
                FRAME_EN    = 8'b0000_1000;
            end else if (k == 8) begin
                FRAME_VALID = 1'b0;
            end
            step();
        end
    endtask

    task automatic test_boundary_load;
        logic [12:0] e;
        logic        r;
        do_reset();
        load_idle(32'h0000_0021, 8'b0000_0011);
        for (int k = 0; k < 36; k++) begin
            if (k < 24) begin
                e = slot_exp(k, 8'hFE, 4'd1, 8'hFD, 4'd2, 1'b1);
                r = (k >= 12) ? 1'b0 : 1'b1;
            end else begin
                e = slot_exp(k - 24, 8'hFB, 4'd7, 8'hFF, 4'd0, 1'b0);
                r = 1'b1;
            end
            n_checks++;
            if ({SEG_SEL, DIGIT_VAL, FRAME_START, FRAME_READY} !== {e, r}) begin
                n_fail++;
                $display("FAIL boundary_load k=%0d got %h want %h", k,
                         {SEG_SEL, DIGIT_VAL, FRAME_START, FRAME_READY}, {e, r});
            end
            if (k == 11) begin
                FRAME_DATA  = 32'h0000_0700;
                FRAME_EN    = 8'b0000_0100;
                FRAME_VALID = 1'b1;
            end else if (k == 12) begin
                FRAME_VALID = 1'b0;
            end
            step();
        end
    endtask

    task automatic test_mask_zero;
        logic [12:0] e;
        logic        r;
        do_reset();
        load_idle(32'h0000_0021, 8'b0000_0011);
        for (int k = 0; k < 30; k++) begin
            if (k < 12) begin
                e = slot_exp(k, 8'hFE, 4'd1, 8'hFD, 4'd2, 1'b1);
                r = (k >= 3) ? 1'b0 : 1'b1;
            end else begin
                e = {8'hFF, 4'h0, 1'b0};
                r = 1'b1;
            end
            n_checks++;
            if ({SEG_SEL, DIGIT_VAL, FRAME_START, FRAME_READY} !== {e, r}) begin
                n_fail++;
                $display("FAIL mask_zero k=%0d got %h want %h", k,
                         {SEG_SEL, DIGIT_VAL, FRAME_START, FRAME_READY}, {e, r});
            end
            if (k == 2) begin
                FRAME_DATA  = 32'h0000_0000;
                FRAME_EN    = 8'b0000_0000;
                FRAME_VALID = 1'b1;
            end else if (k == 3) begin
                FRAME_VALID = 1'b0;
            end
            step();
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        load_idle(32'h0000_4321, 8'b0000_1111);
        for (int k = 0; k < 19; k++) begin
            if (k == 18) begin
                FRAME_DATA  = 32'h0000_0001;
                FRAME_EN    = 8'b0000_0001;
                FRAME_VALID = 1'b1;
            end
            step();
        end
        FRAME_VALID = 1'b0;
        n_checks++;
        if ({SEG_SEL, DIGIT_VAL, FRAME_START, FRAME_READY} !== {8'hF7, 4'd4, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL show_digit3 got %h want %h",
                     {SEG_SEL, DIGIT_VAL, FRAME_START, FRAME_READY}, {8'hF7, 4'd4, 1'b0, 1'b0});
        end
        RESET = 1'b1;
        step();
        for (int i = 0; i < 20; i++) begin
            RESET = 1'b0;
            n_checks++;
            if ({SEG_SEL, DIGIT_VAL, FRAME_START, FRAME_READY} !== {8'hFF, 4'h0, 1'b0, 1'b1}) begin
                n_fail++;
                $display("FAIL reset_mid cyc=%0d got %h want %h", i,
                         {SEG_SEL, DIGIT_VAL, FRAME_START, FRAME_READY}, {8'hFF, 4'h0, 1'b0, 1'b1});
            end
            step();
        end
    endtask

`ifdef SEG_SCAN_BLINK_EN
    task automatic test_blink;
        logic [7:0] es;
        int         f;
        do_reset();
        BLINK_MASK = 8'h01;
        load_idle(32'h0000_0005, 8'b0000_0001);
        for (int k = 0; k < 36; k++) begin
            f  = k / 6;
            es = ((k % 6) < 4 && (f % 4) < 2) ? 8'hFE : 8'hFF;
            n_checks++;
            if (SEG_SEL !== es) begin
                n_fail++;
                $display("FAIL blink k=%0d frame=%0d got %h want %h", k, f, SEG_SEL, es);
            end
            step();
        end
    endtask
`endif

    initial begin
        RESET       = 1'b1;
        FRAME_DATA  = '0;
        FRAME_EN    = '0;
        FRAME_VALID = 1'b0;
`ifdef SEG_SCAN_BLINK_EN
        BLINK_MASK  = '0;
`endif
        test_reset();
        test_basic();
        test_sparse();
        test_pending();
        test_boundary_load();
        test_mask_zero();
        test_reset_mid();
`ifdef SEG_SCAN_BLINK_EN
        test_blink();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Scan scheduler for the multiplexed 7-segment display: time-slices one shared SEG_DEC decoder across NUM_DIG digit positions.
- Holds an active frame and a one-deep pending frame. Accepts new frames from game logic (dice values, keypad digits) through a valid/ready handshake and commits them atomically at frame boundaries.
- Drives the 4-bit digit code into SEG_DEC and the active-low SEG_SEL strobes.

Parameters:
- NUM_DIG, 8, number of digit positions (1..8).
- DIV, 12500, clocks each digit is lit (SHOW duration); minimum 2.
- BLANK_CYC, 16, clocks of all-off between digits (anti-ghosting); minimum 1.

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- FRAME_DATA  in  4*NUM_DIG  digit i code at bits [4i+3:4i]
- FRAME_EN  in  NUM_DIG  per-digit enable mask for the frame
- FRAME_VALID  in  1  producer offers FRAME_DATA/FRAME_EN
- FRAME_READY  out  1  pending slot empty; load occurs on VALID&READY at posedge
- DIGIT_VAL  out  4  code for SEG_DEC (passed through unchanged, including values >9)
- SEG_SEL  out  NUM_DIG  active-low one-hot digit strobe
- FRAME_START  out  1  one-cycle pulse in the first SHOW cycle of each frame

Behaviour:
- Single clock CLK. RESET is synchronous and active-high.
- All outputs are registered.
- Reset values:
  - state IDLE; active data 0; active mask 0; pending empty.
  - FRAME_READY=1, SEG_SEL all ones, DIGIT_VAL=0, FRAME_START=0.
  - Prescaler counter 0.
- A load on FRAME_VALID&FRAME_READY stores data and mask into pending and drops FRAME_READY on the next cycle. FRAME_VALID while READY=0 is ignored.
- States:
  - IDLE: SEG_SEL all ones. If pending is full, the next edge commits pending→active and sets READY=1. If the committed mask is nonzero, go to SHOW at the lowest enabled index with FRAME_START=1; otherwise stay in IDLE.
  - SHOW: SEG_SEL[cur]=0, all other bits 1; DIGIT_VAL=active[cur]. Lasts exactly DIV clocks, then go to BLANK.
  - BLANK: SEG_SEL all ones, DIGIT_VAL=0. Lasts exactly BLANK_CYC clocks. Then go to SHOW at the next enabled index above cur, or take the frame boundary if none remains.
- Frame boundary, leaving BLANK after the last enabled digit:
  - Commit pending if full.
  - Restart at the lowest enabled index of the (possibly new) mask with FRAME_START=1.
  - An all-zero mask goes to IDLE.
- Disabled digits are skipped with zero time cost.
- Simultaneous events:
  - A load accepted on the same edge as a frame boundary does not commit at that boundary. It commits at the next boundary, or on the next cycle if the boundary sent the FSM to IDLE.
- Latency: a load at edge t from IDLE with nonzero mask gives commit and first SHOW at edge t+1, so FRAME_START is high in cycle t+1..t+2.
- Frame period = n_en*(DIV+BLANK_CYC) clocks, where n_en is the number of enabled digits.
- RESET mid-frame returns everything to reset values on that edge and drops any pending frame.
- The prescaler counts 0..DIV-1 or 0..BLANK_CYC-1 and clears on every state change.

Optional Feature:
- Macro SEG_SCAN_BLINK_EN.
- Defined:
  - Adds input BLINK_MASK [NUM_DIG] (sampled at commit with the frame) and parameter BLINK_FRAMES (default 32).
  - A frame counter increments at each boundary and wraps at 2*BLINK_FRAMES.
  - While counter ≥ BLINK_FRAMES, digits with their BLINK_MASK bit set are shown with SEG_SEL all ones for their SHOW slot; slot timing is unchanged.
  - The counter resets to 0 on RESET.
- Undefined: no port, no counter; every enabled digit is lit in its slot.

Decomposition:
- Package seg_scan_pkg:
  - state enum (IDLE, SHOW, BLANK)
  - DIGIT_W=4
  - SEL_OFF (all-ones strobe constant)
  - helper function for the digit field slice
- Sub-module seg_next_digit: combinational priority finder. Inputs are mask and current index plus a "from start" flag; outputs are the next enabled index and a "none" flag. Used for both the frame start and the advance.

Test Plan:
Bench parameters DIV=4, BLANK_CYC=2, NUM_DIG=8.
- Reset then idle → SEG_SEL=8'hFF, READY=1, DIGIT_VAL=0 held for 100 clocks.
- Load data 0x00000021, mask 8'b00000011 → SEG_SEL 8'hFE with DIGIT_VAL=1 for 4 clocks; 8'hFF for 2; 8'hFD with DIGIT_VAL=2 for 4; 8'hFF for 2; repeat. FRAME_START pulses every 12 clocks.
- Mask 8'b10000001, data digit7=6, digit0=5 → digits 1..6 never strobed; period 12 clocks.
- Second load mid-frame → READY=0 until boundary. The old frame finishes intact; the new frame appears exactly at the next FRAME_START. A third VALID during READY=0 is ignored.
- Load with mask 0 while running → current frame completes, then IDLE with SEG_SEL=8'hFF.
- RESET asserted during SHOW of digit 3 → next cycle SEG_SEL=8'hFF, READY=1, pending dropped. With SEG_SCAN_BLINK_EN, BLINK_MASK=8'h01 and BLINK_FRAMES=2 → digit 0 dark in frames 2,3, lit in frames 0,1,4.
